store_aligner: RTL and testbench



---
 rtl/store_aligner_pkg.sv | 32 +++
 rtl/store_lane_aligner.sv | 33 +++
 rtl/store_aligner.sv | 129 ++++++++++++
 tb/tb_store_aligner.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_aligner_pkg.sv
// -----------------------------------------------------------------------------
// store_aligner_pkg
// Shared definitions for the store aligner: store-size encodings, FSM state
// type and a helper that turns a size code into its unshifted byte mask.
// -----------------------------------------------------------------------------
package store_aligner_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    // Byte mask for a store of the given size before lane shifting.
    // The illegal size yields an empty mask so nothing could ever be strobed.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        logic [3:0] m;
        case (size)
            SIZE_B:  m = 4'b0001;
            SIZE_H:  m = 4'b0011;
            SIZE_W:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_lane_aligner.sv
// -----------------------------------------------------------------------------
// store_lane_aligner
// Purely combinational lane steering for a store request.
//   off_i         : byte offset within the word (address bits [1:0])
//   size_i        : store size code (0=byte, 1=half, 2=word, 3=illegal)
//   data_i        : LSB-justified store data
//   shifted_o     : data moved into its byte lanes across two words
//   mask_o        : byte strobes across the same two words
//   need_second_o : store spills into the following word
//   illegal_o     : size code 3
// -----------------------------------------------------------------------------
module store_lane_aligner
    import store_aligner_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] data_i,
    output logic [63:0] shifted_o,
    output logic [7:0]  mask_o,
    output logic        need_second_o,
    output logic        illegal_o
);

    always_comb begin
        // Shift by whole bytes; bytes above the store size ride along but
        // always land in lanes whose strobe is zero.
        shifted_o     = {32'b0, data_i} << {off_i, 3'b000};
        mask_o        = {4'b0000, size_mask(size_i)} << off_i;
        need_second_o = |mask_o[7:4];
        illegal_o     = (size_i == 2'd3);
    end

endmodule

// File: rtl/store_aligner.sv
// -----------------------------------------------------------------------------
// store_aligner
// Turns SB/SH/SW requests into word-aligned memory write beats with byte
// strobes. Stores crossing a word boundary are issued as two beats.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (accepted only in IDLE)
//   req_addr/data/size   : byte address, LSB-justified data, size code
//   mem_valid/mem_ready  : write-beat handshake
//   mem_addr/wdata/wstrb : word-aligned beat, held stable while stalled
//   done                 : one-cycle pulse when the last beat was taken
//   err                  : one-cycle pulse for an illegal size
// -----------------------------------------------------------------------------
module store_aligner
    import store_aligner_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        done,
    output logic        err
);

    state_e      state_q, state_d;
    logic [29:0] waddr_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        second_q;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [63:0] shifted;
    logic [7:0]  mask;
    logic        need_second;
    logic        illegal;
    logic        accept;

    store_lane_aligner u_lane (
        .off_i         (req_addr[1:0]),
        .size_i        (req_size),
        .data_i        (req_data),
        .shifted_o     (shifted),
        .mask_o        (mask),
        .need_second_o (need_second),
        .illegal_o     (illegal)
    );

    assign accept = (state_q == ST_IDLE) && req_valid;

    // State register plus the beat payload captured at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            waddr_q  <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            second_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                waddr_q  <= req_addr[31:2];
                wdata_q  <= shifted;
                wstrb_q  <= mask;
                second_q <= need_second;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = illegal ? ST_ERR : ST_BEAT0;
                    err_d   = illegal;
                end
            end
            ST_BEAT0: begin
                if (mem_ready) begin
                    state_d = second_q ? ST_BEAT1 : ST_IDLE;
                    done_d  = !second_q;
                end
            end
            ST_BEAT1: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: beat fields come straight from the captured registers, so
    // they cannot move while a beat is stalled.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        mem_valid = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
        if (state_q == ST_BEAT1) begin
            // 30-bit word index wraps 0xFFFFFFFC -> 0x00000000 for free.
            mem_addr  = {waddr_q + 30'd1, 2'b00};
            mem_wdata = wdata_q[63:32];
            mem_wstrb = wstrb_q[7:4];
        end else begin
            mem_addr  = {waddr_q, 2'b00};
            mem_wdata = wdata_q[31:0];
            mem_wstrb = (state_q == ST_BEAT0) ? wstrb_q[3:0] : 4'b0000;
        end
        done = done_q;
        err  = err_q;
    end

endmodule

// File: tb/tb_store_aligner.sv
module tb_store_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    // Expected beats for the store currently under test.
    int          exp_nb;
    logic [31:0] exp_addr [2];
    logic [31:0] exp_data [2];
    logic [3:0]  exp_strb [2];

    always #5 clk = ~clk;

    store_aligner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_size  (req_size),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .done      (done),
        .err       (err)
    );

    // Reference model: walk the stored bytes one at a time, find the word
    // each byte falls in and place it in that word's lane.
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int          nbytes;
        logic [31:0] base, ba, w;
        int          k;
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        base   = a & 32'hFFFF_FFFC;
        exp_nb = 0;
        for (int b = 0; b < 2; b++) begin
            exp_addr[b] = 32'h0;
            exp_data[b] = 32'h0;
            exp_strb[b] = 4'h0;
        end
        for (int i = 0; i < nbytes; i++) begin
            ba = a + 32'(i);
            w  = ba & 32'hFFFF_FFFC;
            k  = (w == base) ? 0 : 1;
            if (k + 1 > exp_nb) exp_nb = k + 1;
            exp_addr[k] = w;
            exp_data[k][8*ba[1:0] +: 8] = d[8*i +: 8];
            exp_strb[k][ba[1:0]] = 1'b1;
        end
    endtask

    // Issue one store whose expected beats are in exp_*; each beat is
    // withheld for 'stall' cycles before mem_ready goes high.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input int stall, input string tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        mem_ready = (stall == 0);
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s req_ready: got %b want 1", tag, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom_range(0, 3));
        for (int b = 0; b < exp_nb; b++) begin
            for (int s = 0; s <= stall; s++) begin
                @(negedge clk);
                mem_ready = (s == stall);
                n_checks++;
                if (mem_valid !== 1'b1 || mem_addr !== exp_addr[b] || mem_wdata !== exp_data[b] ||
                    mem_wstrb !== exp_strb[b] || done !== 1'b0 || req_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s beat%0d cyc%0d: got v=%b a=%h d=%h s=%b done=%b rdy=%b want v=1 a=%h d=%h s=%b done=0 rdy=0",
                             tag, b, s, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, req_ready,
                             exp_addr[b], exp_data[b], exp_strb[b]);
                end
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || req_ready !== 1'b1 || mem_valid !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done: got done=%b rdy=%b v=%b err=%b want 1 1 0 0", tag, done, req_ready, mem_valid, err);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || mem_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s done_pulse: got done=%b v=%b want 0 0", tag, done, mem_valid);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
        req_size  = 2'd0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            mem_wstrb !== 4'h0 || done !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: got rdy=%b v=%b a=%h d=%h s=%b done=%b err=%b want 1 0 0 0 0 0 0",
                     req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        exp_nb = 1; exp_addr[0] = 32'h1000; exp_data[0] = 32'hAB00_0000; exp_strb[0] = 4'b1000;
        run_store(32'h0000_1003, 32'h0000_00AB, 2'd0, 0, "sb_off3");
        exp_nb = 1; exp_addr[0] = 32'h2000; exp_data[0] = 32'hBEEF_0000; exp_strb[0] = 4'b1100;
        run_store(32'h0000_2002, 32'h0000_BEEF, 2'd1, 0, "sh_off2");
        exp_nb = 2;
        exp_addr[0] = 32'h3000; exp_data[0] = 32'h2233_4400; exp_strb[0] = 4'b1110;
        exp_addr[1] = 32'h3004; exp_data[1] = 32'h0000_0011; exp_strb[1] = 4'b0001;
        run_store(32'h0000_3001, 32'h1122_3344, 2'd2, 0, "sw_split");
    endtask

    task automatic test_wrap_stall();
        exp_nb = 2;
        exp_addr[0] = 32'hFFFF_FFFC; exp_data[0] = 32'hFE00_0000; exp_strb[0] = 4'b1000;
        exp_addr[1] = 32'h0000_0000; exp_data[1] = 32'h0000_00CA; exp_strb[1] = 4'b0001;
        run_store(32'hFFFF_FFFF, 32'h0000_CAFE, 2'd1, 3, "sh_wrap_stall");
    endtask

    task automatic test_illegal();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_5000;
        req_data  = 32'hDEAD_BEEF;
        req_size  = 2'd3;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b1 || mem_valid !== 1'b0 || req_ready !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL illegal_err: got err=%b v=%b rdy=%b done=%b want 1 0 0 0", err, mem_valid, req_ready, done);
        end
        // Aligned SW offered during the err cycle; accepted once IDLE again.
        req_valid = 1'b1;
        req_addr  = 32'h0000_6000;
        req_data  = 32'hCAFE_F00D;
        req_size  = 2'd2;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0 || mem_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL illegal_recover: got err=%b v=%b rdy=%b want 0 0 1", err, mem_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_6000 || mem_wdata !== 32'hCAFE_F00D || mem_wstrb !== 4'b1111) begin
            n_errors++;
            $display("FAIL after_err_beat: got v=%b a=%h d=%h s=%b want 1 00006000 cafef00d 1111",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL after_err_done: got done=%b err=%b want 1 0", done, err);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h0000_7000;
        req_data  = 32'h0102_0304;
        req_size  = 2'd2;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_done_ready: got done=%b rdy=%b want 1 1", done, req_ready);
        end
        req_valid = 1'b1;
        req_addr  = 32'h0000_0005;
        req_data  = 32'h0000_0077;
        req_size  = 2'd0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_0004 || mem_wdata !== 32'h0000_7700 ||
            mem_wstrb !== 4'b0010 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_beat: got v=%b a=%h d=%h s=%b done=%b want 1 00000004 00007700 0010 0",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, done);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second_done: got %b want 1", done);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h4000_0002;
        req_data  = 32'h5566_7788;
        req_size  = 2'd2;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        n_checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 32'h4000_0004 || mem_wstrb !== 4'b0011) begin
            n_errors++;
            $display("FAIL mid_beat1: got v=%b a=%h s=%b want 1 40000004 0011", mem_valid, mem_addr, mem_wstrb);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            mem_wstrb !== 4'h0 || done !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got v=%b rdy=%b a=%h d=%h s=%b done=%b err=%b want 0 1 0 0 0 0 0",
                     mem_valid, req_ready, mem_addr, mem_wdata, mem_wstrb, done, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || mem_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL post_reset_quiet%0d: got done=%b v=%b want 0 0", i, done, mem_valid);
            end
        end
        model(32'h0000_8001, 32'h0000_00A5, 2'd0);
        run_store(32'h0000_8001, 32'h0000_00A5, 2'd0, 1, "post_reset_sb");
    endtask

    task automatic test_random();
        logic [31:0] a, d;
        logic [1:0]  sz;
        int          stall;
        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            if (n % 8 == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            sz = 2'($urandom_range(0, 2));
            d  = $urandom;
            if (sz == 2'd0) d = d & 32'h0000_00FF;
            if (sz == 2'd1) d = d & 32'h0000_FFFF;
            stall = $urandom_range(0, 2);
            model(a, d, sz);
            run_store(a, d, sz, stall, $sformatf("rand%0d", n));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_wrap_stall();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
